// File: rtl/intarb_pkg.sv
// intarb_pkg: shared definitions for the Unibus interrupt arbiter.
// State encoding, register ID, timeout limit and BR level indices.
package intarb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SACK = 3'd1,
    ST_MAST = 3'd2,
    ST_INTR = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [31:0] INTARB_ID     = 32'h4941_0002;
  localparam logic [9:0]  TIMEOUT_LIMIT = 10'd1000;

  localparam logic [1:0] LEV_BR4 = 2'd0;
  localparam logic [1:0] LEV_BR5 = 2'd1;
  localparam logic [1:0] LEV_BR6 = 2'd2;
  localparam logic [1:0] LEV_BR7 = 2'd3;

endpackage

// File: rtl/intarb_pick.sv
// intarb_pick: combinational priority encoder over the device requests.
// Winner is the highest level; ties go to the lowest device index.
module intarb_pick
  import intarb_pkg::*;
#(
  parameter int NDEV = 8
) (
  input  logic [NDEV-1:0]   intreq,
  input  logic [2*NDEV-1:0] irlev,
  output logic              valid,
  output logic [1:0]        level,
  output logic [3:0]        index
);

  // Scan low level to high and high index to low so the last match wins.
  always_comb begin
    valid = 1'b0;
    level = LEV_BR4;
    index = 4'd0;
    for (int lv = 0; lv < 4; lv++) begin
      for (int i = NDEV - 1; i >= 0; i--) begin
        if (intreq[i] && (irlev[2*i +: 2] == 2'(lv))) begin
          valid = 1'b1;
          level = 2'(lv);
          index = 4'(i);
        end else begin
          valid = valid;
          level = level;
          index = index;
        end
      end
    end
  end

endmodule

// File: rtl/intarb.sv
// intarb: Unibus interrupt arbiter (BR/BG, SACK/BBSY/INTR vector transfer).
// Optional feature: define INTARB_TIMEOUT_EN to abort a stalled transfer
// after 1000 cycles in SACK/INTR; otherwise the arbiter waits forever.
module intarb
  import intarb_pkg::*;
#(
  parameter int NDEV = 8
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                armwrite,
  input  logic                armraddr,
  input  logic                armwaddr,
  input  logic [31:0]         armwdata,
  output logic [31:0]         armrdata,
  input  logic [NDEV-1:0]     dev_intreq,
  input  logic [8*NDEV-1:0]   dev_irvec,
  input  logic [2*NDEV-1:0]   dev_irlev,
  output logic [NDEV-1:0]     dev_intgnt,
  input  logic                init_in_h,
  input  logic [3:0]          bg_in_h,
  output logic [3:0]          bg_out_h,
  output logic [3:0]          br_out_h,
  input  logic                bbsy_in_h,
  input  logic                ssyn_in_h,
  output logic                sack_out_h,
  output logic                bbsy_out_h,
  output logic                intr_out_h,
  output logic [15:0]         d_out_h
);

  state_t          state_r, state_nxt_s;
  logic            enable_r, timedout_r;
  logic [7:0]      lastvec_r;
  logic [15:0]     count_r;
  logic [3:0]      bg_prev_r, bg_rise_s, hold_mask_s;
  logic            pick_valid_s;
  logic [1:0]      pick_level_s;
  logic [3:0]      pick_index_s;
  logic [7:0]      pick_vec_s;
  logic [3:0]      lev_req_s;
  logic            win_valid_r;
  logic [1:0]      win_level_r, gnt_level_r;
  logic [3:0]      win_index_r, gnt_index_r;
  logic [7:0]      win_vec_r, gnt_vec_r;
  logic            claim_s, done_entry_s, timeout_s, arm_wr_s;
  logic [NDEV-1:0] gnt_onehot_s, intgnt_r;
  logic [3:0]      br_r;
  logic            sack_r, bbsy_r, intr_r;
  logic [15:0]     d_r;
  logic            unused_s;

  assign unused_s = ^armwdata[28:0];

  intarb_pick #(.NDEV(NDEV)) u_pick (
    .intreq (dev_intreq),
    .irlev  (dev_irlev),
    .valid  (pick_valid_s),
    .level  (pick_level_s),
    .index  (pick_index_s)
  );

  // Per-level request OR and the vector of the current priority winner.
  always_comb begin
    pick_vec_s = 8'h00;
    lev_req_s  = 4'b0000;
    for (int i = 0; i < NDEV; i++) begin
      pick_vec_s = (pick_index_s == 4'(i)) ? dev_irvec[8*i +: 8] : pick_vec_s;
      lev_req_s  = lev_req_s | ({3'b000, dev_intreq[i]} << dev_irlev[2*i +: 2]);
    end
  end

  // One-hot acknowledge vector for the device being served.
  always_comb begin
    gnt_onehot_s = '0;
    for (int i = 0; i < NDEV; i++) begin
      gnt_onehot_s[i] = (gnt_index_r == 4'(i));
    end
  end

  assign bg_rise_s    = bg_in_h & ~bg_prev_r;
  assign claim_s      = (state_r == ST_IDLE) && enable_r && win_valid_r &&
                        bg_rise_s[win_level_r] && !init_in_h;
  assign done_entry_s = (state_r == ST_INTR) && (state_nxt_s == ST_DONE);
  assign arm_wr_s     = armwrite && armwaddr;

  // Block the grant bit we claimed from travelling further down the chain.
  always_comb begin
    hold_mask_s = 4'b0000;
    if (claim_s) begin
      hold_mask_s = 4'b0001 << win_level_r;
    end else if (state_r != ST_IDLE) begin
      hold_mask_s = 4'b0001 << gnt_level_r;
    end else begin
      hold_mask_s = 4'b0000;
    end
  end

  assign bg_out_h = bg_in_h & ~hold_mask_s;

`ifdef INTARB_TIMEOUT_EN
  logic [9:0] tmo_cnt_r;

  // Cycle counter for the bus handshake; cleared outside the transfer.
  always_ff @(posedge CLOCK) begin
    if (RESET || init_in_h) begin
      tmo_cnt_r <= 10'd0;
    end else if ((state_r == ST_SACK) || (state_r == ST_MAST) || (state_r == ST_INTR)) begin
      tmo_cnt_r <= tmo_cnt_r + 10'd1;
    end else begin
      tmo_cnt_r <= 10'd0;
    end
  end

  assign timeout_s = ((state_r == ST_SACK) || (state_r == ST_INTR)) &&
                     (tmo_cnt_r >= (TIMEOUT_LIMIT - 10'd1));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state logic for the vector transfer sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: state_nxt_s = claim_s ? ST_SACK : ST_IDLE;
      ST_SACK: state_nxt_s = (!bbsy_in_h && !bg_in_h[gnt_level_r]) ? ST_MAST : ST_SACK;
      ST_MAST: state_nxt_s = ST_INTR;
      ST_INTR: state_nxt_s = ssyn_in_h ? ST_DONE : ST_INTR;
      ST_DONE: state_nxt_s = ssyn_in_h ? ST_DONE : ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
    if (timeout_s || init_in_h) begin
      state_nxt_s = ST_IDLE;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // State register plus registered bus outputs derived from the next state.
  always_ff @(posedge CLOCK) begin
    if (RESET || init_in_h) begin
      state_r  <= ST_IDLE;
      br_r     <= 4'b0000;
      sack_r   <= 1'b0;
      bbsy_r   <= 1'b0;
      intr_r   <= 1'b0;
      d_r      <= 16'h0000;
      intgnt_r <= '0;
    end else begin
      state_r  <= state_nxt_s;
      br_r     <= ((state_nxt_s == ST_IDLE) && enable_r) ? lev_req_s : 4'b0000;
      sack_r   <= (state_nxt_s == ST_SACK);
      bbsy_r   <= (state_nxt_s == ST_MAST) || (state_nxt_s == ST_INTR);
      intr_r   <= (state_nxt_s == ST_INTR);
      d_r      <= ((state_nxt_s == ST_MAST) || (state_nxt_s == ST_INTR)) ?
                  {8'h00, gnt_vec_r} : 16'h0000;
      intgnt_r <= done_entry_s ? gnt_onehot_s : '0;
    end
  end

  // Winner tracks requests while idle (aligned with BR); grant latches on claim.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      bg_prev_r   <= 4'b0000;
      win_valid_r <= 1'b0;
      win_level_r <= LEV_BR4;
      win_index_r <= 4'd0;
      win_vec_r   <= 8'h00;
      gnt_level_r <= LEV_BR4;
      gnt_index_r <= 4'd0;
      gnt_vec_r   <= 8'h00;
    end else begin
      bg_prev_r <= bg_in_h;
      if (state_nxt_s == ST_IDLE) begin
        win_valid_r <= pick_valid_s;
        win_level_r <= pick_level_s;
        win_index_r <= pick_index_s;
        win_vec_r   <= pick_vec_s;
      end else begin
        win_valid_r <= win_valid_r;
        win_level_r <= win_level_r;
        win_index_r <= win_index_r;
        win_vec_r   <= win_vec_r;
      end
      if (claim_s) begin
        gnt_level_r <= win_level_r;
        gnt_index_r <= win_index_r;
        gnt_vec_r   <= win_vec_r;
      end else begin
        gnt_level_r <= gnt_level_r;
        gnt_index_r <= gnt_index_r;
        gnt_vec_r   <= gnt_vec_r;
      end
    end
  end

  // ARM-visible control/status: enable, timeout flag, last vector, count.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      enable_r   <= 1'b0;
      timedout_r <= 1'b0;
      lastvec_r  <= 8'h00;
      count_r    <= 16'h0000;
    end else begin
      enable_r <= arm_wr_s ? armwdata[31] : enable_r;
      if (timeout_s && !init_in_h) begin
        timedout_r <= 1'b1;
      end else if (arm_wr_s && armwdata[30]) begin
        timedout_r <= 1'b0;
      end else begin
        timedout_r <= timedout_r;
      end
      if (done_entry_s) begin
        count_r   <= count_r + 16'd1;
        lastvec_r <= gnt_vec_r;
      end else if (arm_wr_s && armwdata[29]) begin
        count_r   <= 16'h0000;
        lastvec_r <= lastvec_r;
      end else begin
        count_r   <= count_r;
        lastvec_r <= lastvec_r;
      end
    end
  end

  assign armrdata   = armraddr ? {enable_r, timedout_r, 6'b000000, lastvec_r, count_r}
                               : INTARB_ID;
  assign br_out_h   = br_r;
  assign sack_out_h = sack_r;
  assign bbsy_out_h = bbsy_r;
  assign intr_out_h = intr_r;
  assign d_out_h    = d_r;
  assign dev_intgnt = intgnt_r;

endmodule

// File: tb/tb_intarb.sv
// tb_intarb: self-checking bench for intarb with a queue-free device model.
module tb_intarb;

  localparam int NDEV = 8;

  logic              CLOCK, RESET;
  logic              armwrite, armraddr, armwaddr;
  logic [31:0]       armwdata, armrdata;
  logic [NDEV-1:0]   dev_intreq, dev_intgnt;
  logic [8*NDEV-1:0] dev_irvec;
  logic [2*NDEV-1:0] dev_irlev;
  logic              init_in_h;
  logic [3:0]        bg_in_h, bg_out_h, br_out_h;
  logic              bbsy_in_h, ssyn_in_h, sack_out_h, bbsy_out_h, intr_out_h;
  logic [15:0]       d_out_h;

  int total = 0;
  int bad   = 0;
  int exp_count = 0;
  logic [7:0] exp_lastvec = 8'h00;

  logic       req_m [NDEV];
  logic [1:0] lev_m [NDEV];
  logic [7:0] vec_m [NDEV];

  intarb #(.NDEV(NDEV)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
    .armwdata(armwdata), .armrdata(armrdata),
    .dev_intreq(dev_intreq), .dev_irvec(dev_irvec), .dev_irlev(dev_irlev),
    .dev_intgnt(dev_intgnt), .init_in_h(init_in_h),
    .bg_in_h(bg_in_h), .bg_out_h(bg_out_h), .br_out_h(br_out_h),
    .bbsy_in_h(bbsy_in_h), .ssyn_in_h(ssyn_in_h),
    .sack_out_h(sack_out_h), .bbsy_out_h(bbsy_out_h), .intr_out_h(intr_out_h),
    .d_out_h(d_out_h)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic drive_devs();
    for (int i = 0; i < NDEV; i++) begin
      dev_intreq[i]         = req_m[i];
      dev_irlev[2*i +: 2]   = lev_m[i];
      dev_irvec[8*i +: 8]   = vec_m[i];
    end
  endtask

  task automatic clear_devs();
    for (int i = 0; i < NDEV; i++) begin
      req_m[i] = 1'b0; lev_m[i] = 2'd0; vec_m[i] = 8'h00;
    end
    drive_devs();
  endtask

  task automatic arm_wr(input logic [31:0] d);
    armwaddr = 1'b1; armwdata = d; armwrite = 1'b1;
    tick();
    armwrite = 1'b0;
  endtask

  // Reference: BR level L is set when any requesting device sits at level L.
  function automatic logic [3:0] model_br();
    logic [3:0] b;
    b = 4'b0000;
    for (int i = 0; i < NDEV; i++) if (req_m[i]) b[lev_m[i]] = 1'b1;
    return b;
  endfunction

  // Reference: winner maximises level*100 - index; -1 when nobody requests.
  function automatic int model_winner();
    int best, score, bscore;
    best = -1; bscore = -1000;
    for (int i = 0; i < NDEV; i++) begin
      score = int'(lev_m[i]) * 100 - i;
      if (req_m[i] && score > bscore) begin best = i; bscore = score; end
    end
    return best;
  endfunction

  // Plays the bus master side of one grant/vector transfer, recording what it saw.
  task automatic bus_cycle(input int lvl, output logic sack_seen,
                           output logic [15:0] d_before, output logic [15:0] d_at_intr,
                           output logic intr_seen, output logic [NDEV-1:0] g1,
                           output logic [NDEV-1:0] g2);
    int n;
    bg_in_h = 4'b0000; bg_in_h[lvl] = 1'b1;
    tick();
    sack_seen = sack_out_h;
    bg_in_h = 4'b0000;
    d_before = 16'h0000;
    n = 0;
    while (!intr_out_h && n < 10) begin
      d_before = d_out_h;
      tick();
      n++;
    end
    intr_seen = intr_out_h;
    d_at_intr = d_out_h;
    ssyn_in_h = 1'b1;
    tick();
    g1 = dev_intgnt;
    tick();
    g2 = dev_intgnt;
    ssyn_in_h = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick(); tick(); tick();
    total++; if (br_out_h !== 4'b0000) begin bad++; $display("FAIL reset_br: got %b want 0000", br_out_h); end
    total++; if ({sack_out_h, bbsy_out_h, intr_out_h} !== 3'b000) begin bad++; $display("FAIL reset_bus: got %b want 000", {sack_out_h, bbsy_out_h, intr_out_h}); end
    total++; if (d_out_h !== 16'h0000 || dev_intgnt !== 8'h00) begin bad++; $display("FAIL reset_d_gnt: got %h/%h want 0/0", d_out_h, dev_intgnt); end
    total++; if (bg_out_h !== 4'b0000) begin bad++; $display("FAIL reset_bg: got %b want 0000", bg_out_h); end
    armraddr = 1'b0; #1;
    total++; if (armrdata !== 32'h49410002) begin bad++; $display("FAIL id_reg: got %h want 49410002", armrdata); end
    armraddr = 1'b1; #1;
    total++; if (armrdata !== 32'h0) begin bad++; $display("FAIL reset_csr: got %h want 0", armrdata); end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic s, ii; logic [15:0] db, di; logic [NDEV-1:0] g1, g2;
    arm_wr(32'h8000_0000);
    req_m[2] = 1'b1; lev_m[2] = 2'd2; vec_m[2] = 8'o100; drive_devs();
    tick();
    total++; if (br_out_h !== 4'b0100) begin bad++; $display("FAIL single_br: got %b want 0100", br_out_h); end
    bus_cycle(2, s, db, di, ii, g1, g2);
    req_m[2] = 1'b0; drive_devs();
    exp_count++; exp_lastvec = 8'o100;
    total++; if (s !== 1'b1) begin bad++; $display("FAIL single_sack: got %b want 1", s); end
    total++; if (db !== 16'o000100) begin bad++; $display("FAIL single_d_early: got %o want 000100", db); end
    total++; if (ii !== 1'b1 || di !== 16'o000100) begin bad++; $display("FAIL single_intr: got %b/%o want 1/000100", ii, di); end
    total++; if (g1 !== 8'b0000_0100 || g2 !== 8'h00) begin bad++; $display("FAIL single_gnt: got %b/%b want 00000100/00000000", g1, g2); end
    tick();
    armraddr = 1'b1; #1;
    total++; if (armrdata !== {1'b1, 1'b0, 6'd0, 8'o100, 16'd1}) begin bad++; $display("FAIL single_csr: got %h want %h", armrdata, {1'b1, 1'b0, 6'd0, 8'o100, 16'd1}); end
  endtask

  task automatic test_priority();
    logic s, ii; logic [15:0] db, di; logic [NDEV-1:0] g1, g2;
    req_m[1] = 1'b1; lev_m[1] = 2'd0; vec_m[1] = 8'o60;
    req_m[5] = 1'b1; lev_m[5] = 2'd0; vec_m[5] = 8'o300; drive_devs();
    tick();
    bus_cycle(0, s, db, di, ii, g1, g2);
    req_m[1] = 1'b0; drive_devs();
    total++; if (di !== 16'o60 || g1 !== 8'b0000_0010) begin bad++; $display("FAIL prio_first: got %o/%b want 60/00000010", di, g1); end
    tick();
    total++; if (br_out_h !== 4'b0001) begin bad++; $display("FAIL prio_br: got %b want 0001", br_out_h); end
    bus_cycle(0, s, db, di, ii, g1, g2);
    req_m[5] = 1'b0; drive_devs();
    total++; if (di !== 16'o300 || g1 !== 8'b0010_0000) begin bad++; $display("FAIL prio_second: got %o/%b want 300/00100000", di, g1); end
    exp_count += 2; exp_lastvec = 8'o300;
    tick();
  endtask

  task automatic test_passthru();
    req_m[3] = 1'b1; lev_m[3] = 2'd0; vec_m[3] = 8'o44; drive_devs();
    tick();
    bg_in_h = 4'b1000; #1;
    total++; if (bg_out_h !== 4'b1000) begin bad++; $display("FAIL pass_bg_now: got %b want 1000", bg_out_h); end
    tick();
    total++; if (sack_out_h !== 1'b0 || bg_out_h !== 4'b1000) begin bad++; $display("FAIL pass_nosack: got %b/%b want 0/1000", sack_out_h, bg_out_h); end
    bg_in_h = 4'b0000; req_m[3] = 1'b0; drive_devs();
    tick();
  endtask

  task automatic test_init_abort();
    int n; logic s, ii; logic [15:0] db, di; logic [NDEV-1:0] g1, g2;
    req_m[4] = 1'b1; lev_m[4] = 2'd1; vec_m[4] = 8'o234; drive_devs();
    tick();
    bg_in_h = 4'b0010;
    tick();
    bg_in_h = 4'b0000;
    n = 0;
    while (!intr_out_h && n < 10) begin tick(); n++; end
    total++; if (intr_out_h !== 1'b1) begin bad++; $display("FAIL init_reach_intr: got %b want 1", intr_out_h); end
    init_in_h = 1'b1;
    tick();
    init_in_h = 1'b0;
    total++; if ({intr_out_h, bbsy_out_h, sack_out_h} !== 3'b000 || d_out_h !== 16'h0) begin bad++; $display("FAIL init_drop: got %b/%h want 000/0", {intr_out_h, bbsy_out_h, sack_out_h}, d_out_h); end
    total++; if (dev_intgnt !== 8'h00) begin bad++; $display("FAIL init_nognt: got %b want 0", dev_intgnt); end
    tick();
    total++; if (br_out_h !== 4'b0010) begin bad++; $display("FAIL init_idle_br: got %b want 0010", br_out_h); end
    armraddr = 1'b1; #1;
    total++; if (armrdata[15:0] !== 16'(exp_count)) begin bad++; $display("FAIL init_count: got %0d want %0d", armrdata[15:0], exp_count); end
    bus_cycle(1, s, db, di, ii, g1, g2);
    req_m[4] = 1'b0; drive_devs();
    exp_count++; exp_lastvec = 8'o234;
    total++; if (di !== 16'o234 || g1 !== 8'b0001_0000) begin bad++; $display("FAIL init_retry: got %o/%b want 234/00010000", di, g1); end
    tick();
  endtask

  task automatic test_disabled();
    arm_wr(32'h0000_0000);
    req_m[0] = 1'b1; lev_m[0] = 2'd3; vec_m[0] = 8'o10; drive_devs();
    tick(); tick();
    total++; if (br_out_h !== 4'b0000) begin bad++; $display("FAIL dis_br: got %b want 0000", br_out_h); end
    bg_in_h = 4'b1111; #1;
    total++; if (bg_out_h !== 4'b1111) begin bad++; $display("FAIL dis_bg: got %b want 1111", bg_out_h); end
    tick();
    total++; if (sack_out_h !== 1'b0) begin bad++; $display("FAIL dis_sack: got %b want 0", sack_out_h); end
    bg_in_h = 4'b0000; req_m[0] = 1'b0; drive_devs();
    tick();
    arm_wr(32'h8000_0000);
    tick();
  endtask

  task automatic test_random();
    int w, guard; logic s, ii; logic [15:0] db, di; logic [NDEV-1:0] g1, g2, eg;
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NDEV; i++) begin
        req_m[i] = 1'($urandom_range(0, 1));
        lev_m[i] = 2'($urandom_range(0, 3));
        vec_m[i] = 8'($urandom_range(0, 255));
      end
      drive_devs();
      guard = 0;
      w = model_winner();
      while (guard < 2 * NDEV) begin
        tick();
        total++; if (br_out_h !== model_br()) begin bad++; $display("FAIL rand_br: got %b want %b", br_out_h, model_br()); end
        w = model_winner();
        if (w < 0) break;
        bus_cycle(int'(lev_m[w]), s, db, di, ii, g1, g2);
        eg = '0; eg[w] = 1'b1;
        total++; if (di !== {8'h00, vec_m[w]} || ii !== 1'b1) begin bad++; $display("FAIL rand_vec: got %h/%b want %h/1", di, ii, {8'h00, vec_m[w]}); end
        total++; if (g1 !== eg || g2 !== '0) begin bad++; $display("FAIL rand_gnt: got %b/%b want %b/0", g1, g2, eg); end
        req_m[w] = 1'b0;
        exp_count++; exp_lastvec = vec_m[w];
        if ($urandom_range(0, 3) == 0) begin
          int j;
          j = int'($urandom_range(0, NDEV - 1));
          if (!req_m[j]) begin
            req_m[j] = 1'b1; lev_m[j] = 2'($urandom_range(0, 3)); vec_m[j] = 8'($urandom_range(0, 255));
          end
        end
        drive_devs();
        guard++;
      end
    end
    armraddr = 1'b1; #1;
    total++; if (armrdata[23:0] !== {exp_lastvec, 16'(exp_count)}) begin bad++; $display("FAIL rand_csr: got %h want %h", armrdata[23:0], {exp_lastvec, 16'(exp_count)}); end
  endtask

`ifdef INTARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    req_m[6] = 1'b1; lev_m[6] = 2'd1; vec_m[6] = 8'o70; drive_devs();
    tick();
    bg_in_h = 4'b0010;
    tick();
    bg_in_h = 4'b0000;
    n = 0;
    while (!intr_out_h && n < 10) begin tick(); n++; end
    n = 0;
    while (intr_out_h && n < 1100) begin
      total++; if (dev_intgnt !== 8'h00) begin bad++; $display("FAIL tmo_gnt: got %b want 0", dev_intgnt); end
      tick(); n++;
    end
    total++; if (n < 900 || n > 1050) begin bad++; $display("FAIL tmo_time: got %0d cycles want about 1000", n); end
    total++; if ({intr_out_h, bbsy_out_h, sack_out_h} !== 3'b000 || d_out_h !== 16'h0) begin bad++; $display("FAIL tmo_drop: got %b/%h want 000/0", {intr_out_h, bbsy_out_h, sack_out_h}, d_out_h); end
    armraddr = 1'b1; #1;
    total++; if (armrdata[30] !== 1'b1 || armrdata[15:0] !== 16'(exp_count)) begin bad++; $display("FAIL tmo_flag: got %h want timedout=1 count=%0d", armrdata, exp_count); end
    tick();
    total++; if (br_out_h !== 4'b0010) begin bad++; $display("FAIL tmo_rebr: got %b want 0010", br_out_h); end
    req_m[6] = 1'b0; drive_devs();
    arm_wr(32'hC000_0000);
    #1;
    total++; if (armrdata[30] !== 1'b0) begin bad++; $display("FAIL tmo_clear: got %b want 0", armrdata[30]); end
    tick();
  endtask
`endif

  initial begin
    RESET = 1'b1; armwrite = 1'b0; armraddr = 1'b0; armwaddr = 1'b0; armwdata = 32'h0;
    init_in_h = 1'b0; bg_in_h = 4'b0000; bbsy_in_h = 1'b0; ssyn_in_h = 1'b0;
    dev_intreq = '0; dev_irvec = '0; dev_irlev = '0;
    clear_devs();
    test_reset();
    test_single();
    test_priority();
    test_passthru();
    test_init_abort();
    test_disabled();
`ifdef INTARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/intarb.md
# intarb

Bus-side interrupt arbiter for the PDP-11 Unibus interface. It collects level-sensitive interrupt requests from device blocks such as the line clock and console interfaces. It drives BR7..BR4, accepts the matching BG grant, and performs the SACK/BBSY/INTR vector transfer. It then returns a one-cycle acknowledge to the winning device so that device can clear its request.

## Interface
- NDEV, 8, number of device request inputs (1..16)
- CLOCK  in  1  100 MHz system clock
- RESET  in  1  synchronous, active-high; clock CLOCK
- armwrite  in  1  ARM register write strobe
- armraddr, armwaddr  in  1  ARM read/write register select (0 = ID, 1 = control/status)
- armwdata  in  32  ARM write data
- armrdata  out  32  ARM read data
- dev_intreq  in  NDEV  per-device request, held until acknowledged
- dev_irvec  in  8*NDEV  per-device vector, bits [7:0] of device i at [8i+7:8i]
- dev_irlev  in  2*NDEV  per-device level, 0..3 = BR4..BR7
- dev_intgnt  out  NDEV  one-cycle acknowledge to the device whose vector was taken
- init_in_h  in  1  bus INIT
- bg_in_h  in  4  BG7..BG4 from upstream, index 3 = BG7
- bg_out_h  out  4  BG passed downstream when not claimed
- br_out_h  out  4  BR7..BR4 to bus
- bbsy_in_h, ssyn_in_h  in  1  bus BBSY, SSYN
- sack_out_h, bbsy_out_h, intr_out_h  out  1  bus SACK, BBSY, INTR
- d_out_h  out  16  vector onto data lines, 0 otherwise

## Operation
- armrdata at raddr 0 = 32'h49410002. At raddr 1 = {enable, timedout, 6'b0, lastvec[7:0], count[15:0]}.
- Write to waddr 1: bit31 sets enable; bit30=1 clears timedout; count is cleared when bit29=1.
- With enable=0, br_out_h=0 and bg_out_h=bg_in_h.
- br_out_h[L] = OR of dev_intreq[i] with dev_irlev[i]==L, gated by enable, while in IDLE. All BR outputs drop in every other state.
- Winner selection: highest level, then lowest device index. The winner is evaluated each cycle in IDLE.
- States:
  - IDLE: wait for a grant.
  - SACK: sack_out_h=1; wait for bbsy_in_h=0 and the granted bg_in_h bit to drop.
  - MAST: bbsy_out_h=1, sack_out_h=0, d_out_h=vector; remain one cycle for deskew.
  - INTR: intr_out_h=1; wait for ssyn_in_h.
  - DONE: drop intr, d, and bbsy; pulse dev_intgnt; wait for ssyn_in_h=0, then return to IDLE.
- Grant claim, IDLE to SACK: the claim happens when bg_in_h[L] rises and the arbiter has a request at exactly level L. The winner index and vector are latched at that moment. The bg_out_h[L] bit is held 0.
- An unclaimed BG is passed through combinationally to bg_out_h.
- A bg_in_h at level L with no local request at L is always passed downstream, even if higher-level local requests exist.
- count increments (wrapping at 16 bits) and lastvec is updated on the DONE entry.
- A device that drops dev_intreq after the claim does not abort the transfer. The latched vector is still delivered.
- init_in_h, or RESET, in any state: all bus outputs go to 0, dev_intgnt goes to 0, and the state becomes IDLE within one cycle. RESET also clears enable, count, lastvec, and timedout.

## Timing
- Reset value of every output is 0, except armrdata, which is combinational.
- BR asserts 1 cycle after dev_intreq is sampled in IDLE.
- From the BG rising edge, sack_out_h=1 on the next cycle.
- MAST lasts 1 cycle. intr_out_h therefore asserts 2 cycles after the SACK exit, and d_out_h is valid 1 cycle before intr_out_h.
- dev_intgnt pulses exactly 1 cycle, on the DONE entry cycle.
- Simultaneous BG and new higher request: the claim uses the winner already latched for level L. New requests wait for the next IDLE.

## Configuration
- INTARB_TIMEOUT_EN defined: a 10-bit counter runs in SACK and INTR. At 1000 cycles (10 µs) it forces all bus outputs low, sets timedout, skips dev_intgnt, and returns to IDLE. The request therefore re-arbitrates.
- INTARB_TIMEOUT_EN undefined: the arbiter waits indefinitely, and timedout reads 0.

## Structure
- A shared package holds:
  - the state encoding (IDLE, SACK, MAST, INTR, DONE);
  - the ID constant 32'h49410002;
  - the timeout limit 1000;
  - level indices BR4=0..BR7=3.
- One sub-module, intarb_pick: combinational priority encoder from dev_intreq/dev_irlev to {valid, level, index}. It is instantiated once.

## Test plan
- Device 2 at level 2 (BR6) requests with vector 8'o100; enable set.
  - br_out_h=4'b0100 next cycle.
  - Raise bg_in_h[2] -> SACK, then with BBSY low -> d_out_h=16'o000100 and INTR.
  - Assert SSYN -> dev_intgnt[2] pulses 1 cycle; count=1, lastvec=8'o100.
- Devices 1 and 5 both at level 0 with vectors 8'o60 and 8'o300 -> after BG4, device 1's vector 8'o60 is delivered first, then device 5's vector 8'o300.
- Local request at level 0 only; bg_in_h[3] asserted -> bg_out_h[3]=1, no SACK.
- init_in_h pulsed during INTR -> intr_out_h, bbsy_out_h, and d_out_h are 0 next cycle; state is IDLE; no dev_intgnt.
- With INTARB_TIMEOUT_EN defined, SSYN is never returned -> outputs drop at 1000 cycles; timedout=1; the request is re-presented on BR.
- enable=0 with a request pending -> br_out_h=0, and bg_in_h=4'b1111 passes to bg_out_h unchanged.
